// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - CPU/DMA requester, memory-side and status signals of mem_port_arbiter
// slave: arbiter side; master: requesters plus memory model side.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic [DW-1:0] dma_rdata;
  logic          dma_ack;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_read;
  logic          mem_write;

  logic          busy;
  logic          owner;

  modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ack,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      output dma_rdata, dma_ack,
      output mem_addr, mem_wdata, mem_read, mem_write,
      input  mem_rdata,
      output busy, owner
  );

  modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ack,
      output dma_req, dma_we, dma_addr, dma_wdata,
      input  dma_rdata, dma_ack,
      input  mem_addr, mem_wdata, mem_read, mem_write,
      output mem_rdata,
      input  busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - CPU/DMA arbiter for the unified memory of the multicycle MIPS core
// Optional MEM_PORT_ARB_RR_EN: round-robin on simultaneous requests (default: CPU priority).
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input logic            clk,
    input logic            rst,
    mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          owner_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] dma_rdata_q;
  logic          cpu_ack_q;
  logic          dma_ack_q;
  logic          mem_read_q;
  logic          mem_write_q;
  logic          busy_q;

  logic          owner_d;
  logic          any_req_d;
  logic          we_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;

  // Winner selection only matters in IDLE; elsewhere the request inputs are ignored.
  always_comb begin
    owner_d   = owner_q;
    any_req_d = bus.cpu_req | bus.dma_req;
    if (bus.cpu_req && bus.dma_req) begin
`ifdef MEM_PORT_ARB_RR_EN
      owner_d = ~owner_q;
`else
      owner_d = 1'b0;
`endif
    end else if (bus.cpu_req) begin
      owner_d = 1'b0;
    end else if (bus.dma_req) begin
      owner_d = 1'b1;
    end
    we_d    = owner_d ? bus.dma_we    : bus.cpu_we;
    addr_d  = owner_d ? bus.dma_addr  : bus.cpu_addr;
    wdata_d = owner_d ? bus.dma_wdata : bus.cpu_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      owner_q     <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_req_d) begin
            state_q     <= ST_ACCESS;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= LAT_M1;
            mem_read_q  <= ~we_d;
            mem_write_q <= we_d;
            busy_q      <= 1'b1;
          end
        end
        ST_ACCESS: begin
          if (cnt_q == 4'd0) begin
            state_q     <= ST_RESP;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            // Read data is only valid in the last access cycle, so capture it here.
            if (!we_q) begin
              if (owner_q) dma_rdata_q <= bus.mem_rdata;
              else         cpu_rdata_q <= bus.mem_rdata;
            end
            if (owner_q) dma_ack_q <= 1'b1;
            else         cpu_ack_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dma_ack   = dma_ack_q;
  assign bus.busy      = busy_q;
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter (MEM_LAT 3 and 1 instances)
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 3;
`ifdef MEM_PORT_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus3 ();
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) u_dut3 (.clk(clk), .rst(rst_n), .bus(bus3));
  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1))   u_dut1 (.clk(clk), .rst(rst_n), .bus(bus1));

  logic [DW-1:0] mem [64];
  assign bus3.mem_rdata = mem[bus3.mem_addr[7:2]];

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  logic [DW-1:0] rd_m [2];
  bit            last_owner;
  bit            exp_seq [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic perturb(input int pm);
    if (pm == 1) begin
      bus3.cpu_addr  = $urandom;
      bus3.cpu_wdata = $urandom;
      bus3.cpu_we    = 1'($urandom_range(0, 1));
      bus3.cpu_req   = 1'($urandom_range(0, 1));
      bus3.dma_addr  = $urandom;
      bus3.dma_wdata = $urandom;
      bus3.dma_we    = 1'($urandom_range(0, 1));
      bus3.dma_req   = 1'($urandom_range(0, 1));
    end else if (pm == 2) begin
      bus3.cpu_addr = 32'h20;
    end
  endtask

  // Called at a negedge while the arbiter is idle with at least one request pending.
  task automatic run_one(input int pm, output bit obs_dma);
    bit            w;
    logic          we_s;
    logic [AW-1:0] a_s;
    logic [DW-1:0] d_s;
    if (bus3.cpu_req && bus3.dma_req) w = RR_EN ? !last_owner : 1'b0;
    else                              w = bus3.dma_req;
    we_s = w ? bus3.dma_we    : bus3.cpu_we;
    a_s  = w ? bus3.dma_addr  : bus3.cpu_addr;
    d_s  = w ? bus3.dma_wdata : bus3.cpu_wdata;
    @(posedge clk);
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      chk("acc_busy",  bus3.busy, 1);
      chk("acc_read",  bus3.mem_read, !we_s);
      chk("acc_write", bus3.mem_write, we_s);
      chk("acc_addr",  bus3.mem_addr, a_s);
      chk("acc_wdata", bus3.mem_wdata, d_s);
      chk("acc_noack", {bus3.cpu_ack, bus3.dma_ack}, 0);
      perturb(pm);
    end
    @(negedge clk);
    if (!we_s) rd_m[w] = mem[a_s[7:2]];
    chk("resp_ack",     {bus3.cpu_ack, bus3.dma_ack}, w ? 2'b01 : 2'b10);
    chk("resp_strobes", {bus3.mem_read, bus3.mem_write}, 0);
    chk("resp_busy",    bus3.busy, 1);
    chk("resp_owner",   bus3.owner, w);
    chk("cpu_rdata",    bus3.cpu_rdata, rd_m[0]);
    chk("dma_rdata",    bus3.dma_rdata, rd_m[1]);
    obs_dma    = bus3.dma_ack;
    last_owner = w;
    @(negedge clk);
    chk("idle_busy", bus3.busy, 0);
    chk("idle_ack",  {bus3.cpu_ack, bus3.dma_ack}, 0);
  endtask

  initial begin
    bit obs;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    {bus3.cpu_req, bus3.cpu_we, bus3.dma_req, bus3.dma_we} = '0;
    {bus3.cpu_addr, bus3.cpu_wdata, bus3.dma_addr, bus3.dma_wdata} = '0;
    {bus1.cpu_req, bus1.cpu_we, bus1.dma_req, bus1.dma_we} = '0;
    {bus1.cpu_addr, bus1.cpu_wdata, bus1.dma_addr, bus1.dma_wdata} = '0;
    bus1.mem_rdata = 32'hDEAD_BEEF;
    rd_m[0] = '0;
    rd_m[1] = '0;
    last_owner = 1'b0;
    for (int i = 0; i < 4; i++) exp_seq[i] = RR_EN ? (i % 2 == 0) : 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_acks",    {bus3.cpu_ack, bus3.dma_ack}, 0);
    chk("rst_strobes", {bus3.mem_read, bus3.mem_write}, 0);
    chk("rst_busy",    bus3.busy, 0);
    chk("rst_owner",   bus3.owner, 0);
    chk("rst_memaddr", {bus3.mem_addr, bus3.mem_wdata}, 0);
    chk("rst_rdata",   {bus3.cpu_rdata, bus3.dma_rdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // MEM_LAT=1 CPU read
    bus1.cpu_req = 1'b1;
    bus1.cpu_addr = 32'h10;
    @(negedge clk);
    chk("l1_read",    bus1.mem_read, 1);
    chk("l1_addr",    bus1.mem_addr, 32'h10);
    chk("l1_noack",   bus1.cpu_ack, 0);
    @(negedge clk);
    chk("l1_ack",     bus1.cpu_ack, 1);
    chk("l1_rdata",   bus1.cpu_rdata, 32'hDEAD_BEEF);
    chk("l1_read_lo", bus1.mem_read, 0);
    chk("l1_dma_ack", bus1.dma_ack, 0);
    bus1.cpu_req = 1'b0;
    @(negedge clk);
    chk("l1_ack_pulse", bus1.cpu_ack, 0);
    chk("l1_idle",      bus1.busy, 0);
    chk("l1_dma_rdata", bus1.dma_rdata, 0);

    // DMA write, 0x40 / 0x12345678
    bus3.dma_req = 1'b1; bus3.dma_we = 1'b1;
    bus3.dma_addr = 32'h40; bus3.dma_wdata = 32'h1234_5678;
    run_one(0, obs);
    bus3.dma_req = 1'b0; bus3.dma_we = 1'b0;

    // CPU read whose address changes mid-access
    bus3.cpu_req = 1'b1; bus3.cpu_we = 1'b0; bus3.cpu_addr = 32'h10;
    run_one(2, obs);
    bus3.cpu_req = 1'b0;

    // Both ports requesting continuously
    bus3.cpu_req = 1'b1; bus3.cpu_addr = 32'h8;  bus3.cpu_we = 1'b0;
    bus3.dma_req = 1'b1; bus3.dma_addr = 32'h44; bus3.dma_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_one(0, obs);
      chk("grant_order", obs, exp_seq[i]);
    end
    bus3.cpu_req = 1'b0; bus3.dma_req = 1'b0;

    // CPU holds req through ack: back-to-back accesses
    bus3.cpu_req = 1'b1; bus3.cpu_we = 1'b0; bus3.cpu_addr = 32'h30;
    run_one(0, obs);
    run_one(0, obs);
    bus3.cpu_req = 1'b0;

    // Randomised traffic, including mid-access input and req changes
    for (int i = 0; i < 25; i++) begin
      bus3.cpu_req   = 1'($urandom_range(0, 1));
      bus3.dma_req   = bus3.cpu_req ? 1'($urandom_range(0, 1)) : 1'b1;
      bus3.cpu_we    = 1'($urandom_range(0, 1));
      bus3.dma_we    = 1'($urandom_range(0, 1));
      bus3.cpu_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      bus3.dma_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      bus3.cpu_wdata = $urandom;
      bus3.dma_wdata = $urandom;
      run_one(1, obs);
    end
    bus3.cpu_req = 1'b0; bus3.dma_req = 1'b0;

    // Reset in the 2nd access cycle of a read
    bus3.cpu_req = 1'b1; bus3.cpu_we = 1'b0; bus3.cpu_addr = 32'h14;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_strobes", {bus3.mem_read, bus3.mem_write}, 0);
    chk("mid_rst_busy",    bus3.busy, 0);
    chk("mid_rst_ack",     {bus3.cpu_ack, bus3.dma_ack}, 0);
    rd_m[0] = '0;
    rd_m[1] = '0;
    last_owner = 1'b0;
    bus3.cpu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      chk("post_rst_noack", {bus3.cpu_ack, bus3.dma_ack, bus3.busy}, 0);
    end
    bus3.cpu_req = 1'b1; bus3.cpu_addr = 32'h24;
    run_one(0, obs);
    bus3.cpu_req = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single unified instruction/data memory of the multicycle MIPS core between two requesters: the CPU, driven by the control FSM's read/write strobes and address mux, and a DMA/loader port used for program load and debug readback. It latches the winning request, drives the memory strobes for a fixed number of access cycles, and returns a one-cycle acknowledge with registered read data. The CPU control FSM must hold in its memory state until `cpu_ack`.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width.
- `MEM_LAT`, 1: memory access length in cycles, legal range 1..15.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `cpu_req`  in  1  CPU request; held high until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  AW  CPU address.
- `cpu_wdata`  in  DW  CPU write data.
- `cpu_rdata`  out  DW  read data; valid while `cpu_ack`=1.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_rdata`, `dma_ack`: same as the CPU port, for the DMA requester.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data; valid in the last access cycle.
- `mem_read`  out  1  memory read strobe.
- `mem_write`  out  1  memory write strobe.
- `busy`  out  1  high in ACCESS and RESP.
- `owner`  out  1  current or most recent grantee: 0 = CPU, 1 = DMA.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any request is high, arbitrate and go to ACCESS.
  - On grant, latch the winner's `we`, `addr` and `wdata` into internal registers.
  - Set `owner` to the winner and load the wait counter with `MEM_LAT-1`.
- ACCESS:
  - `mem_addr` and `mem_wdata` come from the latched registers.
  - Exactly one strobe is high: `mem_read` when latched `we`=0, `mem_write` when latched `we`=1.
  - The counter decrements each cycle. When it is 0, capture `mem_rdata` into the owner's rdata register (reads only) and go to RESP.
- RESP:
  - Strobes are low; the owner's `ack`=1 for one cycle. Go to IDLE.
- Requester inputs are ignored outside IDLE. Changing `addr`, `we` or `wdata` mid-access has no effect.
- If `req` drops mid-access (protocol violation), the access still completes and `ack` is still issued.
- A `req` still high in the cycle after `ack` is treated as a new request.
- Each rdata register holds its last captured value until its next read completes. Writes do not modify it.
- Reset mid-access: strobes, `ack` and `busy` drop immediately. FSM goes to IDLE and the access is abandoned, with no `ack` after reset.
- Reset values:
  - `cpu_ack`=`dma_ack`=0, `mem_read`=`mem_write`=0, `busy`=0, `owner`=0.
  - `mem_addr`=0, `mem_wdata`=0, `cpu_rdata`=`dma_rdata`=0.
  - FSM = IDLE, counter = 0.

## Timing
- Request sampled high in IDLE at edge t:
  - ACCESS covers cycles t+1 .. t+MEM_LAT.
  - `ack` is high in cycle t+MEM_LAT+1.
  - IDLE at t+MEM_LAT+2.
- Minimum spacing between grants is MEM_LAT+2 cycles.
- Read data is registered and becomes visible in the `ack` cycle.
- All outputs are registered or decoded from the state only. There is no combinational path from `req` to any output.
- The counter is 4 bits wide. `MEM_LAT`=1 gives a single ACCESS cycle, with no wrap-around.

## Configuration
- `MEM_PORT_ARB_RR_EN` defined: round-robin arbitration. On a simultaneous request, the port that did not win the previous grant wins; `owner` records the last winner. The first simultaneous request after reset goes to DMA, since `owner` resets to 0.
- Not defined: fixed priority, CPU always wins a simultaneous request. DMA can starve under continuous CPU traffic.

## Test plan
- CPU read, MEM_LAT=1, addr 0x0000_0010, memory returns 0xDEAD_BEEF: `mem_read` is high for 1 cycle; `cpu_ack` is high 2 cycles after the request is sampled, with `cpu_rdata`=0xDEAD_BEEF; `dma_ack` stays 0.
- DMA write, MEM_LAT=3, addr 0x40, data 0x1234_5678: `mem_write` is high for exactly 3 cycles with `mem_addr`=0x40 and `mem_wdata`=0x1234_5678; `dma_ack` is high in the 4th cycle; `dma_rdata` is unchanged.
- Both ports request continuously for 4 grants:
  - with `MEM_PORT_ARB_RR_EN`, grant order is DMA, CPU, DMA, CPU;
  - without it, all 4 grants go to the CPU.
- Change `cpu_addr` from 0x10 to 0x20 in the middle of a MEM_LAT=3 access: `mem_addr` stays 0x10 throughout the access.
- Assert `rst` low in the 2nd ACCESS cycle of a MEM_LAT=3 read: strobes, `busy` and `ack` are 0 immediately; after release no `ack` appears; a fresh request then completes normally.
- Hold `cpu_req` high through `ack`: a second access starts at t+MEM_LAT+2 and produces a second `ack` pulse.
